timer_tick_sequencer: RTL

- Avalon-MM master that owns the 16-bit interval-timer slave (status 0, control 1, period_l 2, period_h 3, snap_l 4, snap_h 5).
- Programs the timer period and starts it in continuous mode with interrupt enabled.
- Services the timer irq, turning each timeout into a one-cycle system tick and a 32-bit tick count.
- Serves on-demand snapshot requests of the live counter. Sits between system-control logic and the timer, replacing CPU-driven timer setup.

---
 rtl/timer_tick_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/timer_tick_sequencer.sv
// Avalon-MM master for the 16-bit interval timer: programs period,
// services timeouts as system ticks and serves counter snapshots.
module timer_tick_sequencer #(
  parameter logic [31:0] DEFAULT_PERIOD = 32'h0003_0D3F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        cfg_req,
  input  logic [31:0] cfg_period,
  input  logic        snap_req,
  output logic        snap_valid,
  output logic [31:0] snap_value,
  output logic        tick,
  output logic [31:0] tick_count,
  output logic        busy,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic [15:0] tmr_readdata,
  input  logic        tmr_irq
);

  localparam logic [15:0] CTL_STOP  = 16'h0008;
  localparam logic [15:0] CTL_START = 16'h0007;

  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_CTRL   = 3'd1;
  localparam logic [2:0] A_PER_L  = 3'd2;
  localparam logic [2:0] A_PER_H  = 3'd3;
  localparam logic [2:0] A_SNAP_L = 3'd4;
  localparam logic [2:0] A_SNAP_H = 3'd5;

  typedef enum logic [3:0] {
    IDLE,
    CFG_STOP,
    CFG_PL,
    CFG_PH,
    CFG_GAP,
    CFG_START,
    CLR_ST,
    RUN,
    STOP_W,
    IRQ_CLR,
    IRQ_WAIT,
    SNAP_W,
    SNAP_RL,
    SNAP_RH,
    SNAP_DONE
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [31:0] period_reg;
  logic        cfg_pending;
  logic        snap_pending;
  logic [15:0] snap_lo;

  logic        bus_cs;
  logic        bus_wn;
  logic [2:0]  bus_addr;
  logic [15:0] bus_data;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      if (enable) nxt = CFG_STOP;
      CFG_STOP:  nxt = CFG_PL;
      CFG_PL:    nxt = CFG_PH;
      CFG_PH:    nxt = CFG_GAP;
      CFG_GAP:   nxt = CFG_START;
      CFG_START: nxt = CLR_ST;
      CLR_ST:    nxt = RUN;
      RUN: begin
        unique case (1'b1)
          !enable:      nxt = STOP_W;
          tmr_irq:      nxt = IRQ_CLR;
          cfg_pending:  nxt = CFG_STOP;
          snap_pending: nxt = SNAP_W;
          default:      nxt = RUN;
        endcase
      end
      STOP_W:    nxt = IDLE;
      IRQ_CLR:   nxt = IRQ_WAIT;
      IRQ_WAIT:  nxt = RUN;
      SNAP_W:    nxt = SNAP_RL;
      SNAP_RL:   nxt = SNAP_RH;
      SNAP_RH:   nxt = SNAP_DONE;
      SNAP_DONE: nxt = RUN;
      default:   nxt = IDLE;
    endcase
  end

  // Bus fields belong to the state being entered, so they register
  // together with it and the access lasts exactly that state's cycle.
  always_comb begin
    bus_cs   = 1'b0;
    bus_wn   = 1'b1;
    bus_addr = 3'd0;
    bus_data = 16'h0000;
    unique case (nxt)
      CFG_STOP, STOP_W: begin
        bus_cs   = 1'b1;
        bus_wn   = 1'b0;
        bus_addr = A_CTRL;
        bus_data = CTL_STOP;
      end
      CFG_PL: begin
        bus_cs   = 1'b1;
        bus_wn   = 1'b0;
        bus_addr = A_PER_L;
        bus_data = period_reg[15:0];
      end
      CFG_PH: begin
        bus_cs   = 1'b1;
        bus_wn   = 1'b0;
        bus_addr = A_PER_H;
        bus_data = period_reg[31:16];
      end
      CFG_START: begin
        bus_cs   = 1'b1;
        bus_wn   = 1'b0;
        bus_addr = A_CTRL;
        bus_data = CTL_START;
      end
      CLR_ST, IRQ_CLR: begin
        bus_cs   = 1'b1;
        bus_wn   = 1'b0;
        bus_addr = A_STATUS;
      end
      SNAP_W: begin
        bus_cs   = 1'b1;
        bus_wn   = 1'b0;
        bus_addr = A_SNAP_L;
      end
      SNAP_RL: begin
        bus_cs   = 1'b1;
        bus_addr = A_SNAP_L;
      end
      SNAP_RH: begin
        bus_cs   = 1'b1;
        bus_addr = A_SNAP_H;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      period_reg     <= DEFAULT_PERIOD;
      cfg_pending    <= 1'b0;
      snap_pending   <= 1'b0;
      snap_lo        <= 16'h0000;
      snap_valid     <= 1'b0;
      snap_value     <= 32'h0;
      tick           <= 1'b0;
      tick_count     <= 32'h0;
      busy           <= 1'b0;
      tmr_address    <= 3'd0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_writedata  <= 16'h0000;
    end else begin
      state          <= nxt;
      tmr_chipselect <= bus_cs;
      tmr_write_n    <= bus_wn;
      tmr_address    <= bus_addr;
      tmr_writedata  <= bus_data;
      busy           <= !(nxt == IDLE || nxt == RUN);

      // A request landing on the entry cycle survives for the next pass.
      if (cfg_req) begin
        period_reg  <= cfg_period;
        cfg_pending <= 1'b1;
      end else if (nxt == CFG_STOP) begin
        cfg_pending <= 1'b0;
      end

      if (snap_req) snap_pending <= 1'b1;
      else if (nxt == SNAP_W) snap_pending <= 1'b0;

      tick <= (nxt == IRQ_CLR);
      if (nxt == IRQ_CLR) tick_count <= tick_count + 32'd1;

      if (state == SNAP_RH) snap_lo <= tmr_readdata;
      snap_valid <= (state == SNAP_DONE);
      if (state == SNAP_DONE) snap_value <= {tmr_readdata, snap_lo};
    end
  end

endmodule
